may_ban_hang: RTL and testbench
===============================

// Module: may_ban_hang
// PURPOSE
//  Four-item vending machine controller: accepts 5/10/20 coins and holds the credit.
//  Sells 1..3 units of a selected item against configurable prices and tracks per-item stock.
//  Returns change one coin per cycle.
//  Sits between the coin acceptor, the selection panel and the dispenser/coin-return actuators.
// PARAMETERS
//  CREDIT_MAX  200  highest credit held; coins that would exceed it are rejected
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  reset      in   1  synchronous, active-low reset
//  cen5       in   1  coin-5 sensor (level; a 0->1 edge = one coin)
//  cen10      in   1  coin-10 sensor (edge = one coin)
//  cen20      in   1  coin-20 sensor (edge = one coin)
//  item1..4   in   1  item select buttons (level)
//  SL         in   2  quantity to buy, 1..3; 0 = no purchase
//  lowpriece  in   2  price code for item1/item2
//  uppriece1  in   2  price code for item3
//  uppriece2  in   2  price code for item4
//  slit1..4   in   6  initial stock, loaded at reset
//  drop5/10/20  out 1  one-cycle coin-return pulse of that denomination
//  dropitem1..4 out 2  units dispensed (one-cycle value; 0 otherwise)
//  SLit1..4   out  6  current stock of each item
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state=IDLE, credit=0, all drop*/dropitem*=0, SLitk<=slitk, edge history=0.
//  - Coins: registered edge detect per input. Credit += 5/10/20 per edge; simultaneous edges are summed.
//  - Coin edges are credited in IDLE, VEND and WAIT_REL, and discarded in CHANGE.
//  - Coin rejection: an edge that would make credit > CREDIT_MAX is not credited.
//    It is echoed on its own drop output the next cycle.
//  - Prices (units of 5):
//    item1 = 5*(lowpriece+1); item2 = 5*(lowpriece+2);
//    item3 = 5*(uppriece1+4); item4 = 5*(uppriece2+5).
//    Cost = price*SL, computed 8-bit unsigned.
//  - FSM states: IDLE, VEND, CHANGE, WAIT_REL.
//  - IDLE: purchase request = exactly one itemk high AND SL!=0. Zero or several items high = no request.
//    - Credit >= cost and SLitk >= SL: go to VEND, latch k and SL.
//    - Credit >= cost but SLitk < SL: refuse; go to CHANGE, refunding the whole credit.
//    - Credit < cost: stay in IDLE, keep credit, wait for more coins.
//  - VEND (1 cycle): dropitemk<=SL and SLitk-=SL on the same edge; credit-=cost. Next state CHANGE.
//  - CHANGE: while credit>0, emit one coin per cycle, largest first.
//    Order: drop20 if credit>=20, else drop10 if >=10, else drop5; credit decreases to match.
//    Go to WAIT_REL when credit reaches 0; on entry with credit==0, go there in the next cycle.
//  - WAIT_REL: stay until all item lines are low, then IDLE. A held button never buys twice.
//  - All outputs registered. At most one drop* pulse per cycle except a rejection echo.
//  - Stock never wraps below 0 (guarded by the SL check). Prices/SL are sampled only in IDLE.
//  - Reset mid-operation: pending change is discarded (credit lost), stock reloads from slitk.
// TESTING
//  - Prices lowpriece=0, stock 10 each; cen20 edge, then item1=1, SL=1.
//    -> dropitem1=1 for 1 cycle, SLit1=9, drop10 then drop5 pulses, credit 0, then WAIT_REL.
//  - Credit 10, item4 (uppriece2=0, price 25), SL=1 -> no vend, credit held.
//    Then cen20 edge -> vend, SLit4-1, change 5.
//  - slit2=1, credit 40, item2 with SL=2 -> refused: dropitem2=0, SLit2=1, drop20, drop20.
//  - cen5, cen10 and cen20 rise in the same cycle -> credit 35.
//    Coins raising credit past 200 are echoed on the matching drop output.
//  - item1 and item3 both high with credit -> no purchase.
//    Item held high after a vend -> second vend only after release and re-press.
//  - reset=0 during CHANGE -> next cycle all drops 0, credit 0, SLitk=slitk.

Source files
------------

// File: rtl/may_ban_hang_if.sv
// Bundle of coin, selection, price, stock and actuator signals for the vending controller.
// The controller takes the slave side; the panel/actuator model takes the master side.
interface may_ban_hang_if;
  logic       cen5, cen10, cen20;
  logic       item1, item2, item3, item4;
  logic [1:0] SL;
  logic [1:0] lowpriece, uppriece1, uppriece2;
  logic [5:0] slit1, slit2, slit3, slit4;
  logic       drop5, drop10, drop20;
  logic [1:0] dropitem1, dropitem2, dropitem3, dropitem4;
  logic [5:0] SLit1, SLit2, SLit3, SLit4;

  modport slave (
    input  cen5, cen10, cen20,
    input  item1, item2, item3, item4,
    input  SL, lowpriece, uppriece1, uppriece2,
    input  slit1, slit2, slit3, slit4,
    output drop5, drop10, drop20,
    output dropitem1, dropitem2, dropitem3, dropitem4,
    output SLit1, SLit2, SLit3, SLit4
  );

  modport master (
    output cen5, cen10, cen20,
    output item1, item2, item3, item4,
    output SL, lowpriece, uppriece1, uppriece2,
    output slit1, slit2, slit3, slit4,
    input  drop5, drop10, drop20,
    input  dropitem1, dropitem2, dropitem3, dropitem4,
    input  SLit1, SLit2, SLit3, SLit4
  );
endinterface

// File: rtl/may_ban_hang.sv
// Four-item vending controller: coin credit with overflow echo, 1..3 unit vending,
// per-item stock tracking and largest-first change return, all outputs registered.
module may_ban_hang #(
  parameter int CREDIT_MAX = 200
) (
  input logic        clk,
  input logic        reset,
  may_ban_hang_if.slave bus
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, WAIT_REL} state_t;

  localparam logic [8:0] MaxCredit = 9'(CREDIT_MAX);

  state_t     r_state, w_nextState;
  logic [7:0] r_credit, w_nextCredit;
  logic       r_prev5, r_prev10, r_prev20;
  logic [1:0] r_selIdx, w_nextSelIdx;
  logic [1:0] r_selQty, w_nextSelQty;
  logic [7:0] r_cost, w_nextCost;
  logic [5:0] r_stock [4];
  logic [5:0] w_nextStock [4];
  logic       r_drop5, r_drop10, r_drop20;
  logic       w_nextDrop5, w_nextDrop10, w_nextDrop20;
  logic [1:0] r_dropItem [4];
  logic [1:0] w_nextDropItem [4];

  logic       w_edge5, w_edge10, w_edge20;
  logic       w_coinsOn;
  logic [7:0] w_coinBase;
  logic [8:0] w_creditIn;
  logic       w_acc5, w_acc10, w_acc20;
  logic       w_rej5, w_rej10, w_rej20;
  logic [3:0] w_items;
  logic       w_reqValid;
  logic [1:0] w_reqIdx;
  logic [7:0] w_unit, w_price, w_reqCost;

  assign w_edge5  = bus.cen5  & ~r_prev5;
  assign w_edge10 = bus.cen10 & ~r_prev10;
  assign w_edge20 = bus.cen20 & ~r_prev20;
  assign w_items  = {bus.item4, bus.item3, bus.item2, bus.item1};

  // Coins accumulate against the credit as it will stand after this cycle's vend,
  // so a coin arriving in VEND is judged against the post-purchase balance.
  always_comb begin
    w_coinBase = (r_state == VEND) ? (r_credit - r_cost) : r_credit;
    w_coinsOn  = (r_state != CHANGE);
    w_creditIn = {1'b0, w_coinBase};
    w_acc5     = 1'b0;
    w_acc10    = 1'b0;
    w_acc20    = 1'b0;
    if (w_coinsOn && w_edge5 && ((w_creditIn + 9'd5) <= MaxCredit)) begin
      w_acc5     = 1'b1;
      w_creditIn = w_creditIn + 9'd5;
    end
    if (w_coinsOn && w_edge10 && ((w_creditIn + 9'd10) <= MaxCredit)) begin
      w_acc10    = 1'b1;
      w_creditIn = w_creditIn + 9'd10;
    end
    if (w_coinsOn && w_edge20 && ((w_creditIn + 9'd20) <= MaxCredit)) begin
      w_acc20    = 1'b1;
      w_creditIn = w_creditIn + 9'd20;
    end
    w_rej5  = w_coinsOn && w_edge5  && !w_acc5;
    w_rej10 = w_coinsOn && w_edge10 && !w_acc10;
    w_rej20 = w_coinsOn && w_edge20 && !w_acc20;
  end

  // Only a single pressed button counts as a request; the price table is in units of 5.
  always_comb begin
    w_reqValid = 1'b0;
    w_reqIdx   = 2'd0;
    case (w_items)
      4'b0001: begin w_reqValid = 1'b1; w_reqIdx = 2'd0; end
      4'b0010: begin w_reqValid = 1'b1; w_reqIdx = 2'd1; end
      4'b0100: begin w_reqValid = 1'b1; w_reqIdx = 2'd2; end
      4'b1000: begin w_reqValid = 1'b1; w_reqIdx = 2'd3; end
      default: begin w_reqValid = 1'b0; w_reqIdx = 2'd0; end
    endcase
    case (w_reqIdx)
      2'd0:    w_unit = {6'd0, bus.lowpriece} + 8'd1;
      2'd1:    w_unit = {6'd0, bus.lowpriece} + 8'd2;
      2'd2:    w_unit = {6'd0, bus.uppriece1} + 8'd4;
      default: w_unit = {6'd0, bus.uppriece2} + 8'd5;
    endcase
    w_price   = w_unit * 8'd5;
    w_reqCost = w_price * {6'd0, bus.SL};
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextCredit   = w_creditIn[7:0];
    w_nextSelIdx   = r_selIdx;
    w_nextSelQty   = r_selQty;
    w_nextCost     = r_cost;
    w_nextStock    = r_stock;
    w_nextDrop5    = w_rej5;
    w_nextDrop10   = w_rej10;
    w_nextDrop20   = w_rej20;
    w_nextDropItem = '{default: 2'd0};
    case (r_state)
      IDLE: begin
        if (w_reqValid && (bus.SL != 2'd0) && (r_credit >= w_reqCost)) begin
          w_nextSelIdx = w_reqIdx;
          w_nextSelQty = bus.SL;
          w_nextCost   = w_reqCost;
          if (r_stock[w_reqIdx] >= {4'd0, bus.SL}) begin
            w_nextState = VEND;
          end else begin
            w_nextState = CHANGE;
          end
        end
      end
      VEND: begin
        w_nextDropItem[r_selIdx] = r_selQty;
        w_nextStock[r_selIdx]    = r_stock[r_selIdx] - {4'd0, r_selQty};
        w_nextState              = CHANGE;
      end
      CHANGE: begin
        w_nextCredit = r_credit;
        if (r_credit == 8'd0) begin
          w_nextState = WAIT_REL;
        end else begin
          if (r_credit >= 8'd20) begin
            w_nextDrop20 = 1'b1;
            w_nextCredit = r_credit - 8'd20;
          end else if (r_credit >= 8'd10) begin
            w_nextDrop10 = 1'b1;
            w_nextCredit = r_credit - 8'd10;
          end else begin
            w_nextDrop5  = 1'b1;
            w_nextCredit = r_credit - 8'd5;
          end
          if (w_nextCredit == 8'd0) begin
            w_nextState = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (w_items == 4'd0) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Reset mid-operation drops any pending change and reloads stock from the inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credit   <= 8'd0;
      r_prev5    <= 1'b0;
      r_prev10   <= 1'b0;
      r_prev20   <= 1'b0;
      r_selIdx   <= 2'd0;
      r_selQty   <= 2'd0;
      r_cost     <= 8'd0;
      r_drop5    <= 1'b0;
      r_drop10   <= 1'b0;
      r_drop20   <= 1'b0;
      r_dropItem <= '{default: 2'd0};
      r_stock[0] <= bus.slit1;
      r_stock[1] <= bus.slit2;
      r_stock[2] <= bus.slit3;
      r_stock[3] <= bus.slit4;
    end else begin
      r_credit   <= w_nextCredit;
      r_prev5    <= bus.cen5;
      r_prev10   <= bus.cen10;
      r_prev20   <= bus.cen20;
      r_selIdx   <= w_nextSelIdx;
      r_selQty   <= w_nextSelQty;
      r_cost     <= w_nextCost;
      r_drop5    <= w_nextDrop5;
      r_drop10   <= w_nextDrop10;
      r_drop20   <= w_nextDrop20;
      r_dropItem <= w_nextDropItem;
      r_stock    <= w_nextStock;
    end
  end

  assign bus.drop5     = r_drop5;
  assign bus.drop10    = r_drop10;
  assign bus.drop20    = r_drop20;
  assign bus.dropitem1 = r_dropItem[0];
  assign bus.dropitem2 = r_dropItem[1];
  assign bus.dropitem3 = r_dropItem[2];
  assign bus.dropitem4 = r_dropItem[3];
  assign bus.SLit1     = r_stock[0];
  assign bus.SLit2     = r_stock[1];
  assign bus.SLit3     = r_stock[2];
  assign bus.SLit4     = r_stock[3];

endmodule

// File: tb/tb_may_ban_hang.sv
// Directed bench for the vending controller: every expected drop pattern, dispensed
// quantity and stock level below is worked out by hand from the price table.
module tb_may_ban_hang;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  may_ban_hang_if bus ();

  may_ban_hang #(.CREDIT_MAX(200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // coins = {cen20, cen10, cen5}, items = {item4..item1}; outputs are sampled 1ns after the edge
  task automatic applyStimulus(input logic [2:0] coins, input logic [3:0] items, input logic [1:0] qty);
    bus.cen5  = coins[0];
    bus.cen10 = coins[1];
    bus.cen20 = coins[2];
    bus.item1 = items[0];
    bus.item2 = items[1];
    bus.item3 = items[2];
    bus.item4 = items[3];
    bus.SL    = qty;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] drops();
    return {29'd0, bus.drop20, bus.drop10, bus.drop5};
  endfunction

  function automatic logic [31:0] items();
    return {24'd0, bus.dropitem4, bus.dropitem3, bus.dropitem2, bus.dropitem1};
  endfunction

  initial begin
    checkCount    = 0;
    passCount     = 0;
    bus.lowpriece = 2'd0;
    bus.uppriece1 = 2'd0;
    bus.uppriece2 = 2'd0;
    bus.slit1     = 6'd10;
    bus.slit2     = 6'd1;
    bus.slit3     = 6'd10;
    bus.slit4     = 6'd10;
    reset         = 1'b0;
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("resetDrops", drops(), 32'd0);
    checkOutput("resetItems", items(), 32'd0);
    checkOutput("resetSLit1", 32'(bus.SLit1), 32'd10);
    checkOutput("resetSLit2", 32'(bus.SLit2), 32'd1);
    checkOutput("resetSLit4", 32'(bus.SLit4), 32'd10);
    reset = 1'b1;

    $display("[TB] basic vend of item1 with 20 coin");
    applyStimulus(3'b100, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0001, 2'd1);
    applyStimulus(3'b000, 4'b0001, 2'd1);
    checkOutput("vend1Item", items(), 32'h01);
    checkOutput("vend1Stock", 32'(bus.SLit1), 32'd9);
    checkOutput("vend1NoDrop", drops(), 32'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("vend1Drop10", drops(), 32'b010);
    checkOutput("vend1ItemPulse", items(), 32'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("vend1Drop5", drops(), 32'b001);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("vend1Done", drops(), 32'd0);

    $display("[TB] insufficient credit for item4 then top-up");
    applyStimulus(3'b010, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    checkOutput("lowCreditItems", items(), 32'd0);
    checkOutput("lowCreditDrops", drops(), 32'd0);
    applyStimulus(3'b100, 4'b1000, 2'd1);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    checkOutput("vend4Item", items(), 32'h40);
    checkOutput("vend4Stock", 32'(bus.SLit4), 32'd9);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    checkOutput("vend4Drop5", drops(), 32'b001);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    checkOutput("heldNoDrop", drops(), 32'd0);
    applyStimulus(3'b100, 4'b1000, 2'd1);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    applyStimulus(3'b000, 4'b1000, 2'd1);
    checkOutput("heldNoRevend", items(), 32'd0);
    checkOutput("heldStock4", 32'(bus.SLit4), 32'd9);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0001, 2'd1);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("repressItem", items(), 32'h01);
    checkOutput("repressStock1", 32'(bus.SLit1), 32'd8);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("repressDrop10", drops(), 32'b010);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("repressDrop5", drops(), 32'b001);
    applyStimulus(3'b000, 4'b0000, 2'd0);

    $display("[TB] refused purchase for lack of stock");
    applyStimulus(3'b100, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b100, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0010, 2'd2);
    applyStimulus(3'b000, 4'b0010, 2'd2);
    checkOutput("refuseDrop20a", drops(), 32'b100);
    checkOutput("refuseNoItem", items(), 32'd0);
    applyStimulus(3'b000, 4'b0010, 2'd2);
    checkOutput("refuseDrop20b", drops(), 32'b100);
    checkOutput("refuseStock2", 32'(bus.SLit2), 32'd1);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("refuseDone", drops(), 32'd0);

    $display("[TB] simultaneous coins give 35, buy 3 x item1");
    applyStimulus(3'b111, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0001, 2'd3);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("multiItem", items(), 32'h03);
    checkOutput("multiStock1", 32'(bus.SLit1), 32'd5);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("multiDrop20", drops(), 32'b100);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("multiDone", drops(), 32'd0);

    $display("[TB] credit ceiling and rejection echo");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b100, 4'b0000, 2'd0);
      applyStimulus(3'b000, 4'b0000, 2'd0);
    end
    checkOutput("fillNoDrop", drops(), 32'd0);
    applyStimulus(3'b001, 4'b0000, 2'd0);
    checkOutput("rejectEcho5", drops(), 32'b001);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("rejectClear", drops(), 32'd0);
    applyStimulus(3'b110, 4'b0000, 2'd0);
    checkOutput("rejectEcho20_10", drops(), 32'b110);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0010, 2'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b000, 4'b0000, 2'd0);
      checkOutput($sformatf("refund200_%0d", i), drops(), 32'b100);
    end
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("refund200Done", drops(), 32'd0);

    $display("[TB] ambiguous selection, zero quantity, reset during change");
    applyStimulus(3'b100, 4'b0000, 2'd0);
    applyStimulus(3'b000, 4'b0101, 2'd1);
    applyStimulus(3'b000, 4'b0101, 2'd1);
    checkOutput("twoItemsNoVend", items(), 32'd0);
    applyStimulus(3'b000, 4'b0001, 2'd0);
    applyStimulus(3'b000, 4'b0001, 2'd0);
    checkOutput("zeroQtyNoVend", items(), 32'd0);
    checkOutput("zeroQtyNoDrop", drops(), 32'd0);
    checkOutput("zeroQtyStock1", 32'(bus.SLit1), 32'd5);
    applyStimulus(3'b000, 4'b0001, 2'd1);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("lastVendItem", items(), 32'h01);
    checkOutput("lastVendStock1", 32'(bus.SLit1), 32'd4);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("lastVendDrop10", drops(), 32'b010);
    reset = 1'b0;
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("midResetDrops", drops(), 32'd0);
    checkOutput("midResetSLit1", 32'(bus.SLit1), 32'd10);
    checkOutput("midResetSLit4", 32'(bus.SLit4), 32'd10);
    reset = 1'b1;
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("creditLostA", drops(), 32'd0);
    applyStimulus(3'b000, 4'b0000, 2'd0);
    checkOutput("creditLostB", drops(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
